// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage valid/ready IEEE-754 multiplier (unpack+multiply, normalise, round+pack).
// Define FMUL_SUBNORMAL_EN for gradual underflow; otherwise subnormal inputs read as zero and tiny results flush.
module fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [2:0]             in_rm,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [4:0]             out_flags,
  output logic [TAG_W-1:0]       out_tag
);
  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;

  logic                   s1_valid_d, s1_valid_q;
  logic [TAG_W-1:0]       s1_tag_d, s1_tag_q;
  logic [2:0]             s1_rm_d, s1_rm_q;
  logic                   s1_sign_d, s1_sign_q;
  logic                   s1_spec_d, s1_spec_q;
  logic [FW-1:0]          s1_sres_d, s1_sres_q;
  logic                   s1_nv_d, s1_nv_q;
  logic signed [EW-1:0]   s1_exp_d, s1_exp_q;
  logic [PW-1:0]          s1_prod_d, s1_prod_q;

  logic                   s2_valid_d, s2_valid_q;
  logic [TAG_W-1:0]       s2_tag_d, s2_tag_q;
  logic [2:0]             s2_rm_d, s2_rm_q;
  logic                   s2_sign_d, s2_sign_q;
  logic                   s2_spec_d, s2_spec_q;
  logic [FW-1:0]          s2_sres_d, s2_sres_q;
  logic                   s2_nv_d, s2_nv_q;
  logic signed [EW-1:0]   s2_exp_d, s2_exp_q;
  logic                   s2_denorm_d, s2_denorm_q;
  logic                   s2_tiny_d, s2_tiny_q;
  logic [SW-1:0]          s2_sig_d, s2_sig_q;
  logic                   s2_guard_d, s2_guard_q;
  logic                   s2_sticky_d, s2_sticky_q;

  logic                   out_valid_d, out_valid_q;
  logic [FW-1:0]          out_res_d, out_res_q;
  logic [4:0]             out_flags_d, out_flags_q;
  logic [TAG_W-1:0]       out_tag_d, out_tag_q;

  // Single global stall: nothing moves while the result register is full and unread.
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_flags = out_flags_q;
  assign out_tag   = out_tag_q;

  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  logic [SW-1:0]    siga, sigb;

  always_comb begin
    ea     = in_a[FW-2 -: EXP_W];
    eb     = in_b[FW-2 -: EXP_W];
    fa     = in_a[MAN_W-1:0];
    fb     = in_b[MAN_W-1:0];
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];
`ifdef FMUL_SUBNORMAL_EN
    a_zero = (ea == '0) && (fa == '0);
    b_zero = (eb == '0) && (fb == '0);
    ea_eff = (ea == '0) ? EXP_W'(1) : ea;
    eb_eff = (eb == '0) ? EXP_W'(1) : eb;
`else
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    ea_eff = ea;
    eb_eff = eb;
`endif
    siga = {ea != '0, fa};
    sigb = {eb != '0, fb};

    s1_valid_d = in_valid;
    s1_tag_d   = in_tag;
    s1_rm_d    = (in_rm > RM_RMM) ? RM_RNE : in_rm;
    s1_sign_d  = in_a[FW-1] ^ in_b[FW-1];
    s1_exp_d   = $signed(EW'(ea_eff)) + $signed(EW'(eb_eff)) - BIAS;
    s1_prod_d  = PW'(siga) * PW'(sigb);
    s1_spec_d  = 1'b1;
    s1_nv_d    = 1'b0;
    s1_sres_d  = QNAN;
    if (a_nan || b_nan) begin
      s1_nv_d = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      s1_nv_d = 1'b1;
    end else if (a_inf || b_inf) begin
      s1_sres_d = {s1_sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      s1_sres_d = {s1_sign_d, {(FW-1){1'b0}}};
    end else begin
      s1_spec_d = 1'b0;
    end
  end

  logic [PW-1:0]        pn, psh;
  logic signed [EW-1:0] en;
  logic                 lost;
`ifdef FMUL_SUBNORMAL_EN
  localparam int LZ_W = $clog2(PW + 1);
  logic [LZ_W-1:0] lz;
  logic [EW-1:0]   sh;
`endif

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
    s2_rm_d    = s1_rm_q;
    s2_sign_d  = s1_sign_q;
    s2_spec_d  = s1_spec_q;
    s2_sres_d  = s1_sres_q;
    s2_nv_d    = s1_nv_q;
`ifdef FMUL_SUBNORMAL_EN
    lz = '0;
    for (int i = 0; i < PW; i++) begin
      if (s1_prod_q[i]) lz = LZ_W'(PW - 1 - i);
    end
    pn = s1_prod_q << lz;
    en = s1_exp_q + ONE - $signed(EW'(lz));
    sh = '0;
    s2_denorm_d = 1'b0;
    // Below the normal range: shift into the denormal position, everything shifted out is sticky.
    if (en < ONE) begin
      s2_denorm_d = 1'b1;
      sh = ONE - en;
      if (sh > EW'(PW)) sh = EW'(PW);
    end
    psh  = pn >> sh;
    lost = |(pn & ~({PW{1'b1}} << sh));
    s2_tiny_d = s2_denorm_d;
    s2_exp_d  = s2_denorm_d ? '0 : en;
`else
    if (s1_prod_q[PW-1]) begin
      pn = s1_prod_q;
      en = s1_exp_q + ONE;
    end else begin
      pn = s1_prod_q << 1;
      en = s1_exp_q;
    end
    psh         = pn;
    lost        = 1'b0;
    s2_denorm_d = 1'b0;
    s2_tiny_d   = 1'b0;
    s2_exp_d    = en;
`endif
    s2_sig_d    = psh[PW-1 -: SW];
    s2_guard_d  = psh[PW-1-SW];
    s2_sticky_d = (|psh[PW-2-SW:0]) || lost;
  end

  logic                 inexact, inc, ovf, flush;
  logic [SW:0]          sig_r;
  logic signed [EW-1:0] eo;
  logic [FW-1:0]        inf_r, max_r;

  always_comb begin
    inexact = s2_guard_q || s2_sticky_q;
    case (s2_rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_sign_q && inexact;
      RM_RUP:  inc = !s2_sign_q && inexact;
      RM_RMM:  inc = s2_guard_q;
      default: inc = s2_guard_q && (s2_sticky_q || s2_sig_q[0]);
    endcase
    sig_r = {1'b0, s2_sig_q} + (SW+1)'(inc);
    // A carry out of the fraction bumps the exponent; a denormal rounding up into the hidden bit becomes exp=1.
    eo = s2_exp_q + $signed(EW'(sig_r[SW])) + $signed(EW'(s2_denorm_q & sig_r[MAN_W]));
    ovf   = (eo >= EMAX);
    flush = 1'b0;
`ifndef FMUL_SUBNORMAL_EN
    flush = (eo < ONE);
`endif
    inf_r = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    max_r = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    out_valid_d = s2_valid_q;
    out_tag_d   = s2_tag_q;
    out_res_d   = {s2_sign_q, eo[EXP_W-1:0], sig_r[MAN_W-1:0]};
    out_flags_d = {3'b000, s2_tiny_q && inexact, inexact};
    if (s2_spec_q) begin
      out_res_d   = s2_sres_q;
      out_flags_d = {s2_nv_q, 4'b0000};
    end else if (ovf) begin
      out_flags_d = 5'b00101;
      case (s2_rm_q)
        RM_RTZ:  out_res_d = max_r;
        RM_RDN:  out_res_d = s2_sign_q ? inf_r : max_r;
        RM_RUP:  out_res_d = s2_sign_q ? max_r : inf_r;
        default: out_res_d = inf_r;
      endcase
    end else if (flush) begin
      out_res_d   = {s2_sign_q, {(FW-1){1'b0}}};
      out_flags_d = 5'b00011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_rm_q     <= '0;
      s1_sign_q   <= 1'b0;
      s1_spec_q   <= 1'b0;
      s1_sres_q   <= '0;
      s1_nv_q     <= 1'b0;
      s1_exp_q    <= '0;
      s1_prod_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_tag_q    <= '0;
      s2_rm_q     <= '0;
      s2_sign_q   <= 1'b0;
      s2_spec_q   <= 1'b0;
      s2_sres_q   <= '0;
      s2_nv_q     <= 1'b0;
      s2_exp_q    <= '0;
      s2_denorm_q <= 1'b0;
      s2_tiny_q   <= 1'b0;
      s2_sig_q    <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_flags_q <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_rm_q     <= s1_rm_d;
      s1_sign_q   <= s1_sign_d;
      s1_spec_q   <= s1_spec_d;
      s1_sres_q   <= s1_sres_d;
      s1_nv_q     <= s1_nv_d;
      s1_exp_q    <= s1_exp_d;
      s1_prod_q   <= s1_prod_d;
      s2_valid_q  <= s2_valid_d;
      s2_tag_q    <= s2_tag_d;
      s2_rm_q     <= s2_rm_d;
      s2_sign_q   <= s2_sign_d;
      s2_spec_q   <= s2_spec_d;
      s2_sres_q   <= s2_sres_d;
      s2_nv_q     <= s2_nv_d;
      s2_exp_q    <= s2_exp_d;
      s2_denorm_q <= s2_denorm_d;
      s2_tiny_q   <= s2_tiny_d;
      s2_sig_q    <= s2_sig_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_flags_q <= out_flags_d;
      out_tag_q   <= out_tag_d;
    end
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed cases, backpressure/reset, and random traffic against an arithmetic fp32 model.
module tb_fmul_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_res;
  logic [2:0]  in_rm;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  out_flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [40:0] sb[$];

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_flags(out_flags), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Exact product m*2^e rounded to a 24-bit significand at quantum 2^q.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm_in,
                                  output logic [31:0] res, output logic [4:0] fl);
    longint ma, mb, m, kept, rem, half, frac;
    int ea, eb, e, p, big_e, q, sh, bexp;
    bit s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inexact, above, tie, up, uf;
    logic [2:0] rm;
    rm = (rm_in > 3'd4) ? 3'd0 : rm_in;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    a_nan = (ea == 255) && (ma != 0);
    b_nan = (eb == 255) && (mb != 0);
    a_inf = (ea == 255) && (ma == 0);
    b_inf = (eb == 255) && (mb == 0);
`ifdef FMUL_SUBNORMAL_EN
    a_zero = (ea == 0) && (ma == 0);
    b_zero = (eb == 0) && (mb == 0);
`else
    a_zero = (ea == 0);
    b_zero = (eb == 0);
`endif
    fl = 5'b0;
    if (a_nan || b_nan) begin
      res = 32'h7FC00000;
      fl  = {(a_nan && !a[22]) || (b_nan && !b[22]), 4'b0};
      return;
    end
    if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      res = 32'h7FC00000;
      fl  = 5'b10000;
      return;
    end
    if (a_inf || b_inf) begin res = {s, 8'hFF, 23'h0}; return; end
    if (a_zero || b_zero) begin res = {s, 31'h0}; return; end
    if (ea == 0) ea = 1; else ma = ma + (longint'(1) << 23);
    if (eb == 0) eb = 1; else mb = mb + (longint'(1) << 23);
    m = ma * mb;
    e = ea + eb - 300;
    p = 0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    big_e = p + e;
    q = big_e - 23;
`ifdef FMUL_SUBNORMAL_EN
    if (q < -149) q = -149;
`endif
    sh = q - e;
    above = 0; tie = 0;
    if (sh <= 0) begin
      kept = m <<< (-sh); inexact = 0;
    end else if (sh > 50) begin
      kept = 0; inexact = 1;
    end else begin
      kept = m >> sh;
      rem  = m - (kept << sh);
      half = longint'(1) << (sh - 1);
      inexact = (rem != 0);
      above = (rem > half);
      tie   = (rem == half);
    end
    case (rm)
      3'd0:    up = above || (tie && kept[0]);
      3'd1:    up = 0;
      3'd2:    up = s && inexact;
      3'd3:    up = !s && inexact;
      default: up = above || tie;
    endcase
    kept = kept + longint'(up);
    if (kept == (longint'(1) << 24)) begin kept = longint'(1) << 23; q++; end
    if (kept >= (longint'(1) << 23)) begin
      bexp = q + 150; frac = kept - (longint'(1) << 23);
    end else begin
      bexp = 0; frac = kept;
    end
`ifdef FMUL_SUBNORMAL_EN
    uf = ((big_e + 127) < 1) && inexact;
`else
    uf = 0;
`endif
    if (bexp >= 255) begin
      fl = 5'b00101;
      case (rm)
        3'd1:    res = {s, 31'h7F7FFFFF};
        3'd2:    res = s ? 32'hFF800000 : 32'h7F7FFFFF;
        3'd3:    res = s ? 32'hFF7FFFFF : 32'h7F800000;
        default: res = {s, 31'h7F800000};
      endcase
    end else if (bexp < 1 && kept >= (longint'(1) << 23)) begin
      res = {s, 31'h0};
      fl  = 5'b00011;
    end else begin
      res = {s, 8'(bexp), 23'(frac)};
      fl  = {3'b000, uf, inexact};
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 10))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(1, 70));
      4:       e = 8'($urandom_range(190, 254));
      5:       begin e = 8'($urandom_range(1, 254)); f = '0; end
      6:       begin e = 8'h00; f = '0; end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                       input logic [31:0] er, input logic [4:0] ef, input logic [3:0] tg);
    int lat;
    @(negedge clk);
    in_a = a; in_b = b; in_rm = rm; in_tag = tg; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_lat"}, 64'(lat), 64'd3);
    check({nm, "_res"}, 64'(out_res), 64'(er));
    check({nm, "_flags"}, 64'(out_flags), 64'(ef));
    check({nm, "_tag"}, 64'(out_tag), 64'(tg));
  endtask

  task automatic sample_out();
    logic [40:0] x;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        x = sb.pop_front();
        check("rnd_res", 64'(out_res), 64'(x[31:0]));
        check("rnd_flags", 64'(out_flags), 64'(x[36:32]));
        check("rnd_tag", 64'(out_tag), 64'(x[40:37]));
      end
    end
  endtask

  task automatic bp_test();
    logic [31:0] er; logic [4:0] ef;
    int tag_n, acc, nxt;
    tag_n = 1; acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = (tag_n <= 5);
      in_a = 32'h3F800000 + (32'(tag_n) << 20); in_b = 32'h40000000; in_rm = 3'd0; in_tag = 4'(tag_n);
      #1;
      if (in_valid && in_ready) begin tag_n++; acc++; end
    end
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    ref_mul(32'h3F800000 + (32'd1 << 20), 32'h40000000, 3'd0, er, ef);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_hold_tag", 64'(out_tag), 64'd1);
      check("bp_hold_res", 64'(out_res), 64'(er));
    end
    nxt = 1;
    for (int c = 0; c < 20 && nxt <= 5; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (tag_n <= 5);
      in_a = 32'h3F800000 + (32'(tag_n) << 20); in_tag = 4'(tag_n);
      #1;
      if (out_valid) begin
        ref_mul(32'h3F800000 + (32'(nxt) << 20), 32'h40000000, 3'd0, er, ef);
        check("bp_order_tag", 64'(out_tag), 64'(nxt));
        check("bp_order_res", 64'(out_res), 64'(er));
        nxt++;
      end
      if (in_valid && in_ready) tag_n++;
    end
    check("bp_received", 64'(nxt - 1), 64'd5);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk);
  endtask

  task automatic reset_test();
    int seen;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000; in_tag = 4'(c);
    end
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_flushed", 64'(seen), 64'd0);
  endtask

  task automatic random_phase(input int ncyc);
    logic [31:0] a, b, er; logic [4:0] ef; logic [2:0] rm;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      a = rnd_op(); b = rnd_op(); rm = 3'($urandom_range(0, 7));
      in_a = a; in_b = b; in_rm = rm; in_tag = 4'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      sample_out();
      if (in_valid && in_ready) begin
        ref_mul(a, b, rm, er, ef);
        sb.push_back({in_tag, ef, er});
      end
    end
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      sample_out();
    end
    check("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_rm = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_res", 64'(out_res), 64'd0);
    check("reset_out_flags", 64'(out_flags), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    do_op("t1",      32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 4'd1);
    do_op("t2_rne",  32'h3F800001, 32'h3FC00000, 3'd0, 32'h3FC00002, 5'b00001, 4'd2);
    do_op("t2_rtz",  32'h3F800001, 32'h3FC00000, 3'd1, 32'h3FC00001, 5'b00001, 4'd3);
    do_op("t2_rup",  32'h3F800001, 32'h3FC00000, 3'd3, 32'h3FC00002, 5'b00001, 4'd4);
    do_op("t2_rdn",  32'h3F800001, 32'h3FC00000, 3'd2, 32'h3FC00001, 5'b00001, 4'd5);
    do_op("t2_rm7",  32'h3F800001, 32'h3FC00000, 3'd7, 32'h3FC00002, 5'b00001, 4'd6);
    do_op("t3_rne",  32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'b00101, 4'd7);
    do_op("t3_rtz",  32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'b00101, 4'd8);
    do_op("t3_rup",  32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'b00101, 4'd9);
    do_op("t4_infz", 32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b10000, 4'd10);
    do_op("t4_snan", 32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'b10000, 4'd11);
    do_op("t4_inf",  32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'b00000, 4'd12);
`ifdef FMUL_SUBNORMAL_EN
    do_op("t6_sub",  32'h00400000, 32'h40000000, 3'd0, 32'h00800000, 5'b00000, 4'd13);
`else
    do_op("t6_sub",  32'h00400000, 32'h40000000, 3'd0, 32'h00000000, 5'b00000, 4'd13);
`endif

    bp_test();
    reset_test();
    random_phase(4000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
